// File: rtl/timer_pkg.sv
// Shared FSM state type and mode encodings for the lap countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRunning,
    StPaused,
    StExpired
  } timer_state_e;

  localparam logic MODE_STOPWATCH = 1'b0;
  localparam logic MODE_COUNTDOWN = 1'b1;

endpackage

// File: rtl/lap_fifo.sv
// Circular lap FIFO: drops pushes when full (sticky overflow), allows push+pop when full,
// and a synchronous flush that also clears the overflow flag.
module lap_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_cnt;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop_ok  = i_pop && !w_empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (i_flush) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push_ok && !w_pop_ok) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_pop_ok && !w_push_ok) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (i_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/lap_countdown_timer.sv
// Stopwatch / countdown timer with a prescaled tick, lap capture FIFO and expiry ring.
// All outputs come straight from registers or from state decode.
module lap_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 4,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic               clockSignal,
  input  logic               reset,
  input  logic               modeSelect,
  input  logic               startOrStop,
  input  logic               splitOrReset,
  input  logic               load,
  input  logic [COUNT_W-1:0] loadValue,
  input  logic               lapRead,
  output logic [COUNT_W-1:0] countValue,
  output logic               running,
  output logic [COUNT_W-1:0] lapValue,
  output logic               lapValid,
  output logic               lapOverflow,
  output logic               ringSound
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);

  timer_state_e       r_state;
  timer_state_e       w_state_next;
  logic [PW-1:0]      r_presc;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] w_count_next;
  logic               r_mode;

  logic w_tick;
  logic w_start_ok;
  logic w_split;
  logic w_expire;
  logic w_lap_push;
  logic w_lap_flush;

  assign w_tick      = (r_state == StRunning) && (r_presc == PRESC_LAST);
  // A countdown from zero would expire immediately, so such a start is refused.
  assign w_start_ok  = startOrStop && !((modeSelect == MODE_COUNTDOWN) && (r_count == '0));
  assign w_split     = splitOrReset && !startOrStop;
  assign w_expire    = (r_mode == MODE_COUNTDOWN) && w_tick && (r_count == COUNT_ONE);
  assign w_lap_push  = (r_state == StRunning) && (r_mode == MODE_STOPWATCH) && w_split;
  assign w_lap_flush = (r_state == StPaused) && w_split;

  always_ff @(posedge clockSignal or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_start_ok) w_state_next = StRunning;
      end
      StRunning: begin
        if (w_expire) begin
          w_state_next = StExpired;
        end else if (startOrStop) begin
          w_state_next = StPaused;
        end
      end
      StPaused: begin
        if (startOrStop) begin
          w_state_next = StRunning;
        end else if (w_split) begin
          w_state_next = StIdle;
        end
      end
      StExpired: begin
        if (startOrStop || splitOrReset) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    running   = (r_state == StRunning);
    ringSound = (r_state == StExpired);
  end

  always_comb begin
    w_count_next = r_count;
    case (r_state)
      StIdle: begin
        if (!w_start_ok && load) w_count_next = loadValue;
      end
      StRunning: begin
        if (w_tick) begin
          if (r_mode == MODE_STOPWATCH) begin
            if (r_count != COUNT_MAX) w_count_next = r_count + 1'b1;
          end else begin
            w_count_next = r_count - 1'b1;
          end
        end
      end
      StPaused: begin
        if (w_split) w_count_next = '0;
      end
      StExpired: begin
        if (startOrStop || splitOrReset) w_count_next = '0;
      end
      default: w_count_next = '0;
    endcase
  end

  always_ff @(posedge clockSignal or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_presc <= '0;
      r_mode  <= MODE_STOPWATCH;
    end else begin
      r_count <= w_count_next;
      // Held at zero in IDLE so every run starts a fresh tick period; frozen while paused.
      if (r_state == StIdle) begin
        r_presc <= '0;
      end else if (r_state == StRunning) begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
      end
      if ((r_state == StIdle) && w_start_ok) begin
        r_mode <= modeSelect;
      end
    end
  end

  lap_fifo #(
    .WIDTH(COUNT_W),
    .DEPTH(LAP_DEPTH)
  ) u_lap_fifo (
    .i_clk      (clockSignal),
    .i_rst      (reset),
    .i_push     (w_lap_push),
    .i_pop      (lapRead),
    .i_flush    (w_lap_flush),
    .i_data     (r_count),
    .o_data     (lapValue),
    .o_valid    (lapValid),
    .o_overflow (lapOverflow)
  );

  assign countValue = r_count;

endmodule

// File: tb/tb_lap_countdown_timer.sv
// Bench for lap_countdown_timer: directed stimulus, an abstract behavioural model compared every
// cycle, and literal expectations pinning the model.
module tb_lap_countdown_timer;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned COUNT_W   = 16;
  localparam int unsigned LAP_DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               modeSelect;
  logic               startOrStop;
  logic               splitOrReset;
  logic               load;
  logic [COUNT_W-1:0] loadValue;
  logic               lapRead;
  logic [COUNT_W-1:0] countValue;
  logic               running;
  logic [COUNT_W-1:0] lapValue;
  logic               lapValid;
  logic               lapOverflow;
  logic               ringSound;

  always #5 clk = ~clk;

  lap_countdown_timer #(
    .TICK_DIV (TICK_DIV),
    .COUNT_W  (COUNT_W),
    .LAP_DEPTH(LAP_DEPTH)
  ) dut (
    .clockSignal (clk),
    .reset       (rst),
    .modeSelect  (modeSelect),
    .startOrStop (startOrStop),
    .splitOrReset(splitOrReset),
    .load        (load),
    .loadValue   (loadValue),
    .lapRead     (lapRead),
    .countValue  (countValue),
    .running     (running),
    .lapValue    (lapValue),
    .lapValid    (lapValid),
    .lapOverflow (lapOverflow),
    .ringSound   (ringSound)
  );

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mstate_e;

  mstate_e     m_st;
  int unsigned m_cnt;
  bit          m_mode;
  int unsigned m_elapsed;  // RUNNING cycles since the last start from idle
  int unsigned laps[$];
  bit          m_ovf;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st      = M_IDLE;
    m_cnt     = 0;
    m_mode    = 1'b0;
    m_elapsed = 0;
    laps.delete();
    m_ovf     = 1'b0;
  endtask

  task automatic model_step();
    bit          st;
    bit          sp;
    bit          tick;
    bit          push;
    int unsigned pv;
    st   = startOrStop;
    sp   = splitOrReset;
    tick = 1'b0;
    push = 1'b0;
    pv   = 0;
    if (lapRead && laps.size() != 0) void'(laps.pop_front());
    case (m_st)
      M_IDLE: begin
        if (st && !(modeSelect && m_cnt == 0)) begin
          m_st      = M_RUN;
          m_mode    = modeSelect;
          m_elapsed = 0;
        end else if (load) begin
          m_cnt = 32'(loadValue);
        end
      end
      M_RUN: begin
        tick = (m_elapsed % TICK_DIV) == TICK_DIV - 1;
        m_elapsed++;
        if (!m_mode && sp && !st) begin
          push = 1'b1;
          pv   = m_cnt;
        end
        if (tick) begin
          if (!m_mode) begin
            if (m_cnt < 65535) m_cnt++;
          end else begin
            m_cnt--;
          end
        end
        if (m_mode && tick && m_cnt == 0) m_st = M_EXP;
        else if (st) m_st = M_PAUSE;
      end
      M_PAUSE: begin
        if (st) begin
          m_st = M_RUN;
        end else if (sp) begin
          m_st  = M_IDLE;
          m_cnt = 0;
          laps.delete();
          m_ovf = 1'b0;
        end
      end
      M_EXP: begin
        if (st || sp) begin
          m_st  = M_IDLE;
          m_cnt = 0;
        end
      end
      default: m_st = M_IDLE;
    endcase
    if (push) begin
      if (laps.size() < LAP_DEPTH) laps.push_back(pv);
      else m_ovf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_count", 32'(countValue), m_cnt);
      chk("cmp_running", 32'(running), 32'(m_st == M_RUN));
      chk("cmp_ring", 32'(ringSound), 32'(m_st == M_EXP));
      chk("cmp_lap_valid", 32'(lapValid), 32'(laps.size() != 0));
      chk("cmp_lap_value", 32'(lapValue), (laps.size() != 0) ? laps[0] : 0);
      chk("cmp_overflow", 32'(lapOverflow), 32'(m_ovf));
    end
  end

  task automatic cyc();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    startOrStop  = 1'b0;
    splitOrReset = 1'b0;
    load         = 1'b0;
    lapRead      = 1'b0;
  endtask

  task automatic wait_count(input int unsigned t);
    int k;
    k = 0;
    while (32'(countValue) != t && k < 64) begin
      cyc();
      k++;
    end
    chk("wait_count", 32'(countValue), t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int unsigned lap_exp[4];
    int unsigned split_at[5];
    lap_exp  = '{3, 5, 7, 9};
    split_at = '{3, 5, 7, 9, 11};
    rst          = 1'b1;
    modeSelect   = 1'b0;
    startOrStop  = 1'b0;
    splitOrReset = 1'b0;
    load         = 1'b0;
    loadValue    = '0;
    lapRead      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(countValue), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_valid", 32'(lapValid), 0);
    chk("rst_ring", 32'(ringSound), 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Stopwatch run, pause, resume; modeSelect toggles outside IDLE must be ignored.
    startOrStop = 1'b1;
    cyc();
    modeSelect = 1'b1;
    repeat (40) cyc();
    startOrStop = 1'b1;
    cyc();
    chk("sw_pause_count", 32'(countValue), 10);
    chk("sw_pause_running", 32'(running), 0);
    startOrStop = 1'b1;
    cyc();
    repeat (8) cyc();
    startOrStop = 1'b1;
    cyc();
    chk("sw_resume_count", 32'(countValue), 12);
    modeSelect   = 1'b0;
    splitOrReset = 1'b1;
    cyc();
    chk("sw_clear_count", 32'(countValue), 0);

    // Laps with overflow, reads, empty read, then push+pop while full and flush.
    startOrStop = 1'b1;
    cyc();
    foreach (split_at[i]) begin
      wait_count(split_at[i]);
      splitOrReset = 1'b1;
      cyc();
    end
    chk("lap_overflow", 32'(lapOverflow), 1);
    foreach (lap_exp[i]) begin
      chk("lap_head", 32'(lapValue), lap_exp[i]);
      lapRead = 1'b1;
      cyc();
    end
    chk("lap_drained_valid", 32'(lapValid), 0);
    chk("lap_drained_value", 32'(lapValue), 0);
    lapRead = 1'b1;
    cyc();
    repeat (4) begin
      splitOrReset = 1'b1;
      cyc();
      cyc();
    end
    splitOrReset = 1'b1;
    lapRead      = 1'b1;
    cyc();
    chk("full_pushpop_valid", 32'(lapValid), 1);
    startOrStop = 1'b1;
    cyc();
    splitOrReset = 1'b1;
    cyc();
    chk("flush_valid", 32'(lapValid), 0);
    chk("flush_overflow", 32'(lapOverflow), 0);

    // Stopwatch saturation.
    loadValue = 16'hFFFE;
    load      = 1'b1;
    cyc();
    startOrStop = 1'b1;
    cyc();
    repeat (12) cyc();
    chk("sat_count", 32'(countValue), 32'hFFFF);
    chk("sat_running", 32'(running), 1);
    startOrStop = 1'b1;
    cyc();
    splitOrReset = 1'b1;
    cyc();

    // Countdown from 3: ring in cycle 13 counting the start cycle as 0.
    loadValue = 16'd3;
    load      = 1'b1;
    cyc();
    modeSelect  = 1'b1;
    startOrStop = 1'b1;
    cyc();
    k = 0;
    while (!ringSound && k < 30) begin
      cyc();
      k++;
    end
    chk("cd_ring_cycle", 32'(k + 1), 13);
    chk("cd_ring_count", 32'(countValue), 0);
    splitOrReset = 1'b1;  // ignored in countdown RUNNING, here EXPIRED exits via start
    startOrStop  = 1'b1;
    cyc();
    chk("cd_stop_count", 32'(countValue), 0);
    chk("cd_stop_ring", 32'(ringSound), 0);

    // Expiry cleared by splitOrReset.
    loadValue = 16'd1;
    load      = 1'b1;
    cyc();
    startOrStop = 1'b1;
    cyc();
    repeat (5) cyc();
    splitOrReset = 1'b1;
    cyc();
    chk("cd_split_ring", 32'(ringSound), 0);

    // Simultaneous start+split in RUNNING, then load ignored while paused.
    modeSelect  = 1'b0;
    startOrStop = 1'b1;
    cyc();
    repeat (6) cyc();
    startOrStop  = 1'b1;
    splitOrReset = 1'b1;
    cyc();
    chk("both_running", 32'(running), 0);
    chk("both_no_lap", 32'(lapValid), 0);
    loadValue = 16'd99;
    load      = 1'b1;
    cyc();
    chk("paused_load", 32'(countValue), 1);
    splitOrReset = 1'b1;
    cyc();

    // Asynchronous reset mid-countdown, then countdown start from zero refused.
    loadValue = 16'd3;
    load      = 1'b1;
    cyc();
    modeSelect  = 1'b1;
    startOrStop = 1'b1;
    cyc();
    wait_count(2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_count", 32'(countValue), 0);
    chk("arst_running", 32'(running), 0);
    chk("arst_ring", 32'(ringSound), 0);
    chk("arst_lap_value", 32'(lapValue), 0);
    chk("arst_valid", 32'(lapValid), 0);
    chk("arst_overflow", 32'(lapOverflow), 0);
    cyc();
    rst         = 1'b0;
    modeSelect  = 1'b1;
    startOrStop = 1'b1;
    cyc();
    chk("cd_zero_start", 32'(running), 0);
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
